// File: rtl/ingress_injection_scheduler_if.sv
// Bundle of the harness-control and per-ingress grant signals of the
// ingress injection scheduler.
//   master : test harness / flit-generator side (drives start, abort, ingress_ready)
//   slave  : scheduler side (drives grants, flit ids, status and cycle count)
// Ports carried:
//   start, abort                 run control pulses
//   ingress_ready[N]             per-ingress grant acceptance
//   inject_valid[N]              per-ingress injection grant
//   inject_flit_id[N*CNT_W]      per-ingress flit index, slice i = [i*CNT_W +: CNT_W]
//   busy, done, stall_err        run status
//   cycle_count[CNT_W]           RUN cycles this run, saturating
interface ingress_injection_scheduler_if #(
  parameter int NUM_INGRESSES = 4,
  parameter int CNT_W         = 16
);
  logic                             start;
  logic                             abort;
  logic [NUM_INGRESSES-1:0]         ingress_ready;
  logic [NUM_INGRESSES-1:0]         inject_valid;
  logic [NUM_INGRESSES*CNT_W-1:0]   inject_flit_id;
  logic                             busy;
  logic                             done;
  logic                             stall_err;
  logic [CNT_W-1:0]                 cycle_count;

  modport master (
    output start, abort, ingress_ready,
    input  inject_valid, inject_flit_id, busy, done, stall_err, cycle_count
  );

  modport slave (
    input  start, abort, ingress_ready,
    output inject_valid, inject_flit_id, busy, done, stall_err, cycle_count
  );
endinterface

// File: rtl/ingress_injection_scheduler.sv
// Paces NUM_INGRESSES independent ingress units during a NoC test run.
// Each ingress earns injection credit at INJECTION_RATE percent of cycles,
// gets one grant per flit until NUM_FLITS have been issued, then the run
// reports done. Also exports a RUN cycle counter and a stall watchdog.
// Ports:
//   clock  in  clock, all state on posedge
//   reset  in  asynchronous reset, active-low
//   bus    slave modport of ingress_injection_scheduler_if
//          (start/abort/ingress_ready in; inject_valid/inject_flit_id/
//           busy/done/stall_err/cycle_count out)
//
// state   | meaning
// IDLE    | waiting for start, all grants off
// RUN     | pacing and granting flits
// DONE    | every ingress issued NUM_FLITS; pacing frozen, counters held
module ingress_injection_scheduler #(
  parameter int NUM_INGRESSES  = 4,
  parameter int NUM_FLITS      = 16,
  parameter int INJECTION_RATE = 100,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT        = 1024
) (
  input logic clock,
  input logic reset,
  ingress_injection_scheduler_if.slave bus
);

  generate
    if (INJECTION_RATE < 1 || INJECTION_RATE > 100) begin : g_bad_rate
      $error("INJECTION_RATE must be within 1..100");
    end
  endgenerate

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int               IDLE_W      = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] TIMEOUT_C  = IDLE_W'(TIMEOUT);
  localparam logic [7:0]       RATE_C      = 8'(INJECTION_RATE);
  localparam logic [CNT_W-1:0] NUM_FLITS_C = CNT_W'(NUM_FLITS);

  logic [1:0]               state;
  logic                     run;
  logic                     start_ok;
  logic [NUM_INGRESSES-1:0] valid;
  logic [NUM_INGRESSES-1:0] fire;
  logic [NUM_INGRESSES-1:0] last;
  logic [CNT_W-1:0]         cycle_cnt;
  logic [IDLE_W-1:0]        idle_cnt;
  logic [IDLE_W-1:0]        idle_next;
  logic                     stall;

  assign run      = (state == ST_RUN);
  assign start_ok = bus.start & ~bus.abort & (state != ST_RUN);

  for (genvar i = 0; i < NUM_INGRESSES; i++) begin : g_ing
    logic [7:0]       acc;
    logic [7:0]       sum;
    logic             pending;
    logic [CNT_W-1:0] flit_id;
    logic [CNT_W-1:0] remaining;

    assign sum      = acc + RATE_C;
    assign valid[i] = run & pending & (remaining != '0);
    assign fire[i]  = valid[i] & bus.ingress_ready[i];
    // This ingress has nothing left after the current cycle.
    assign last[i]  = (remaining == '0) | (fire[i] & (remaining == CNT_W'(1)));
    assign bus.inject_flit_id[i*CNT_W +: CNT_W] = flit_id;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        acc       <= '0;
        pending   <= 1'b0;
        flit_id   <= '0;
        remaining <= '0;
      end else if (bus.abort) begin
        acc       <= '0;
        pending   <= 1'b0;
        flit_id   <= '0;
        remaining <= '0;
      end else if (start_ok) begin
        acc       <= '0;
        pending   <= 1'b0;
        flit_id   <= '0;
        remaining <= NUM_FLITS_C;
      end else if (run) begin
        // A held pending flit blocks accumulation so at most one flit of
        // credit is ever banked under backpressure.
        if (!pending || fire[i]) begin
          if (sum >= 8'd100) begin
            acc     <= sum - 8'd100;
            pending <= 1'b1;
          end else begin
            acc <= sum;
            if (fire[i]) pending <= 1'b0;
          end
        end
        if (fire[i]) begin
          remaining <= remaining - CNT_W'(1);
          flit_id   <= flit_id + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else if (bus.abort) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (bus.start) state <= ST_RUN;
        ST_RUN:  if (&last) state <= ST_DONE;
        ST_DONE: if (bus.start) state <= ST_RUN;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    idle_next = idle_cnt;
    if (|fire) idle_next = '0;
    else if (idle_cnt != TIMEOUT_C) idle_next = idle_cnt + IDLE_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= '0;
      idle_cnt  <= '0;
      stall     <= 1'b0;
    end else if (bus.abort || start_ok) begin
      cycle_cnt <= '0;
      idle_cnt  <= '0;
      stall     <= 1'b0;
    end else if (run) begin
      if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + CNT_W'(1);
      idle_cnt <= idle_next;
      if (idle_next == TIMEOUT_C) stall <= 1'b1;
    end
  end

  assign bus.inject_valid = valid;
  assign bus.busy         = run;
  assign bus.done         = (state == ST_DONE);
  assign bus.stall_err    = stall;
  assign bus.cycle_count  = cycle_cnt;

endmodule

// File: tb/tb_ingress_injection_scheduler.sv
// Bench for ingress_injection_scheduler. Two instances:
//   dut_a : RATE=100, 2 ingresses, 4 flits, TIMEOUT=8
//   dut_b : RATE=50,  1 ingress,   3 flits, TIMEOUT=16
// Cycle vectors give inputs and expected outputs per cycle; a scoreboard
// queue per ingress holds the flit ids expected on each fire.
module tb_ingress_injection_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ingress_injection_scheduler_if #(.NUM_INGRESSES(2), .CNT_W(16)) ia ();
  ingress_injection_scheduler_if #(.NUM_INGRESSES(1), .CNT_W(16)) ib ();

  ingress_injection_scheduler #(
    .NUM_INGRESSES(2), .NUM_FLITS(4), .INJECTION_RATE(100), .CNT_W(16), .TIMEOUT(8)
  ) dut_a (.clock(clk), .reset(rst_n), .bus(ia));

  ingress_injection_scheduler #(
    .NUM_INGRESSES(1), .NUM_FLITS(3), .INJECTION_RATE(50), .CNT_W(16), .TIMEOUT(16)
  ) dut_b (.clock(clk), .reset(rst_n), .bus(ib));

  typedef struct {
    logic        sel;
    logic        start;
    logic        abort;
    logic [1:0]  ready;
    logic [1:0]  exp_valid;
    logic        exp_busy;
    logic        exp_done;
    logic [15:0] exp_cc;
    logic        exp_stall;
  } vec_t;

  vec_t vecs[$];
  int qa0[$];
  int qa1[$];
  int qb[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mkv(input logic sel, input logic st, input logic ab,
                               input logic [1:0] rdy, input logic [1:0] ev,
                               input logic bz, input logic dn,
                               input logic [15:0] cc, input logic stl);
    vec_t v;
    v.sel = sel; v.start = st; v.abort = ab; v.ready = rdy; v.exp_valid = ev;
    v.exp_busy = bz; v.exp_done = dn; v.exp_cc = cc; v.exp_stall = stl;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, required %0h", nm, $time, act, exp);
    end
  endtask

  // Scoreboard: pop the expected id whenever a grant is accepted.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ia.inject_valid[0] && ia.ingress_ready[0]) begin
        if (qa0.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL a0_grant @%0t: got id %0d, required no grant", $time, ia.inject_flit_id[15:0]);
        end else check("a0_flit_id", 32'(ia.inject_flit_id[15:0]), 32'(qa0.pop_front()));
      end
      if (ia.inject_valid[1] && ia.ingress_ready[1]) begin
        if (qa1.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL a1_grant @%0t: got id %0d, required no grant", $time, ia.inject_flit_id[31:16]);
        end else check("a1_flit_id", 32'(ia.inject_flit_id[31:16]), 32'(qa1.pop_front()));
      end
      if (ib.inject_valid[0] && ib.ingress_ready[0]) begin
        if (qb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL b0_grant @%0t: got id %0d, required no grant", $time, ib.inject_flit_id[15:0]);
        end else check("b0_flit_id", 32'(ib.inject_flit_id[15:0]), 32'(qb.pop_front()));
      end
    end
  end

  task automatic flush(input logic sel);
    if (!sel) begin qa0.delete(); qa1.delete(); end
    else qb.delete();
  endtask

  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    if (!v.sel) begin
      ia.start = v.start; ia.abort = v.abort; ia.ingress_ready = v.ready;
      ib.start = 1'b0;    ib.abort = 1'b0;
    end else begin
      ib.start = v.start; ib.abort = v.abort; ib.ingress_ready = v.ready[0];
      ia.start = 1'b0;    ia.abort = 1'b0;
    end
    // Start is accepted only outside RUN and when abort is not asserted.
    if (v.start && !v.abort && !v.exp_busy) begin
      if (!v.sel) begin
        for (int k = 0; k < 4; k++) begin qa0.push_back(k); qa1.push_back(k); end
      end else begin
        for (int k = 0; k < 3; k++) qb.push_back(k);
      end
    end
    @(negedge clk);
    if (!v.sel) begin
      check("a_valid", 32'(ia.inject_valid), 32'(v.exp_valid));
      check("a_busy", 32'(ia.busy), 32'(v.exp_busy));
      check("a_done", 32'(ia.done), 32'(v.exp_done));
      check("a_cycle_count", 32'(ia.cycle_count), 32'(v.exp_cc));
      check("a_stall_err", 32'(ia.stall_err), 32'(v.exp_stall));
    end else begin
      check("b_valid", 32'(ib.inject_valid), 32'(v.exp_valid));
      check("b_busy", 32'(ib.busy), 32'(v.exp_busy));
      check("b_done", 32'(ib.done), 32'(v.exp_done));
      check("b_cycle_count", 32'(ib.cycle_count), 32'(v.exp_cc));
      check("b_stall_err", 32'(ib.stall_err), 32'(v.exp_stall));
    end
    #1;
    if (v.abort) flush(v.sel);
  endtask

  task automatic run_vecs();
    for (int r = 0; r < vecs.size(); r++) apply(vecs[r]);
    vecs.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    ia.start = 1'b0; ia.abort = 1'b0; ia.ingress_ready = 2'b00;
    ib.start = 1'b0; ib.abort = 1'b0; ib.ingress_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_valid", 32'(ia.inject_valid), 32'd0);
    check("rst_busy", 32'(ia.busy), 32'd0);
    check("rst_done", 32'(ia.done), 32'd0);
    check("rst_stall_err", 32'(ia.stall_err), 32'd0);
    check("rst_cycle_count", 32'(ia.cycle_count), 32'd0);

    // T1: rate 100, both ingresses ready
    vecs.push_back(mkv(0,1,0,3, 0,0,0,0,0));
    vecs.push_back(mkv(0,0,0,3, 0,1,0,0,0));
    vecs.push_back(mkv(0,0,0,3, 3,1,0,1,0));
    vecs.push_back(mkv(0,0,0,3, 3,1,0,2,0));
    vecs.push_back(mkv(0,0,0,3, 3,1,0,3,0));
    vecs.push_back(mkv(0,0,0,3, 3,1,0,4,0));
    vecs.push_back(mkv(0,0,0,3, 0,0,1,5,0));
    vecs.push_back(mkv(0,0,0,3, 0,0,1,5,0));
    // T3: restart from DONE, ingress0 backpressured c2..c4, start in RUN ignored
    vecs.push_back(mkv(0,1,0,3, 0,0,1,5,0));
    vecs.push_back(mkv(0,0,0,3, 0,1,0,0,0));
    vecs.push_back(mkv(0,0,0,2, 3,1,0,1,0));
    vecs.push_back(mkv(0,0,0,2, 3,1,0,2,0));
    vecs.push_back(mkv(0,0,0,2, 3,1,0,3,0));
    vecs.push_back(mkv(0,0,0,3, 3,1,0,4,0));
    vecs.push_back(mkv(0,1,0,3, 1,1,0,5,0));
    vecs.push_back(mkv(0,0,0,3, 1,1,0,6,0));
    vecs.push_back(mkv(0,0,0,3, 1,1,0,7,0));
    vecs.push_back(mkv(0,0,0,3, 0,0,1,8,0));
    // T4: no ready at all, watchdog trips after 8 idle RUN cycles, then abort
    vecs.push_back(mkv(0,1,0,0, 0,0,1,8,0));
    vecs.push_back(mkv(0,0,0,0, 0,1,0,0,0));
    for (int c = 2; c <= 8; c++) vecs.push_back(mkv(0,0,0,0, 3,1,0,16'(c-1),0));
    vecs.push_back(mkv(0,0,0,0, 3,1,0,8,1));
    vecs.push_back(mkv(0,0,1,0, 3,1,0,9,1));
    vecs.push_back(mkv(0,0,0,0, 0,0,0,0,0));
    // T5: abort on the 2nd fire, then a fresh run restarts ids at 0
    vecs.push_back(mkv(0,1,0,3, 0,0,0,0,0));
    vecs.push_back(mkv(0,0,0,3, 0,1,0,0,0));
    vecs.push_back(mkv(0,0,0,3, 3,1,0,1,0));
    vecs.push_back(mkv(0,0,1,3, 3,1,0,2,0));
    vecs.push_back(mkv(0,0,0,3, 0,0,0,0,0));
    vecs.push_back(mkv(0,1,0,3, 0,0,0,0,0));
    vecs.push_back(mkv(0,0,0,3, 0,1,0,0,0));
    for (int c = 2; c <= 5; c++) vecs.push_back(mkv(0,0,0,3, 3,1,0,16'(c-1),0));
    vecs.push_back(mkv(0,0,0,3, 0,0,1,5,0));
    // T2: rate 50 on dut_b, grants on alternate cycles
    vecs.push_back(mkv(1,1,0,1, 0,0,0,0,0));
    vecs.push_back(mkv(1,0,0,1, 0,1,0,0,0));
    vecs.push_back(mkv(1,0,0,1, 0,1,0,1,0));
    vecs.push_back(mkv(1,0,0,1, 1,1,0,2,0));
    vecs.push_back(mkv(1,0,0,1, 0,1,0,3,0));
    vecs.push_back(mkv(1,0,0,1, 1,1,0,4,0));
    vecs.push_back(mkv(1,0,0,1, 0,1,0,5,0));
    vecs.push_back(mkv(1,0,0,1, 1,1,0,6,0));
    vecs.push_back(mkv(1,0,0,1, 0,0,1,7,0));
    run_vecs();

    check("a0_sb_left", 32'(qa0.size()), 32'd0);
    check("a1_sb_left", 32'(qa1.size()), 32'd0);
    check("b0_sb_left", 32'(qb.size()), 32'd0);

    // T6: asynchronous reset in the middle of a run
    vecs.push_back(mkv(0,1,0,3, 0,0,1,5,0));
    vecs.push_back(mkv(0,0,0,3, 0,1,0,0,0));
    vecs.push_back(mkv(0,0,0,3, 3,1,0,1,0));
    run_vecs();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(ia.inject_valid), 32'd0);
    check("arst_busy", 32'(ia.busy), 32'd0);
    check("arst_done", 32'(ia.done), 32'd0);
    check("arst_cycle_count", 32'(ia.cycle_count), 32'd0);
    check("arst_flit_id", 32'(ia.inject_flit_id), 32'd0);
    flush(1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Full run, then start+abort together in DONE leaves the block IDLE.
    vecs.push_back(mkv(0,1,0,3, 0,0,0,0,0));
    vecs.push_back(mkv(0,0,0,3, 0,1,0,0,0));
    for (int c = 2; c <= 5; c++) vecs.push_back(mkv(0,0,0,3, 3,1,0,16'(c-1),0));
    vecs.push_back(mkv(0,0,0,3, 0,0,1,5,0));
    vecs.push_back(mkv(0,1,1,3, 0,0,1,5,0));
    vecs.push_back(mkv(0,0,0,3, 0,0,0,0,0));
    vecs.push_back(mkv(0,1,1,3, 0,0,0,0,0));
    vecs.push_back(mkv(0,0,0,3, 0,0,0,0,0));
    run_vecs();

    check("a0_sb_end", 32'(qa0.size()), 32'd0);
    check("a1_sb_end", 32'(qa1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
